// File: rtl/proc_pkg.sv
// Shared definitions for the processor DIN/Run/Done interface: opcode field,
// feeder state encoding and the step in which Done is expected per opcode.
package proc_pkg;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

  localparam int OPC_HI = 8;
  localparam int OPC_LO = 6;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PEND = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  localparam logic [1:0] DONE_STEP_SHORT = 2'd1;
  localparam logic [1:0] DONE_STEP_LONG  = 2'd3;

  // Register moves finish in step 1; every ALU op needs the full frame.
  function automatic logic [1:0] done_step(input logic [2:0] op);
    return (op == OP_MV || op == OP_MVI) ? DONE_STEP_SHORT : DONE_STEP_LONG;
  endfunction

endpackage

// File: rtl/instr_feeder_prog_mem.sv
// Program store: one synchronous write port, two combinational read ports
// so an instruction and its mvi immediate are visible together.
module prog_mem #(
  parameter int AW = 5,
  parameter int W  = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr0,
  input  logic [AW-1:0] raddr1,
  output logic [W-1:0]  rdata0,
  output logic [W-1:0]  rdata1
);

  logic [W-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata0 = mem_q[raddr0];
  assign rdata1 = mem_q[raddr1];

endmodule

// File: rtl/instr_feeder.sv
// Drives DIN/Run one instruction per 4-step frame from a loadable program
// memory, checks Done timing, counts retired instructions and halts at Last.
module instr_feeder
  import proc_pkg::*;
#(
  parameter int AW = 5,
  parameter int W  = 16
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          WrEn,
  input  logic [AW-1:0] WrAddr,
  input  logic [W-1:0]  WrData,
  input  logic          Start,
  input  logic [AW-1:0] Last,
  output logic [W-1:0]  DIN,
  output logic          Run,
  input  logic          Done,
  output logic          Busy,
  output logic          Halted,
  output logic          ProtoErr,
  output logic [W-1:0]  Retired
);

  logic [1:0]    state_q, state_d;
  logic [1:0]    phase_q;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] last_q, last_d;
  logic          perr_q, perr_d;
  logic          halted_q, halted_d;
  logic [W-1:0]  ret_q, ret_d;

  logic [AW-1:0] pc1;
  logic [W-1:0]  rd0, rd1;
  logic [2:0]    opcode;
  logic          is_mvi;
  logic          halt_hit;

  assign pc1 = pc_q + 1'b1;

  prog_mem #(.AW(AW), .W(W)) u_mem (
    .clk    (Clock),
    .we     (WrEn & ~Busy),
    .waddr  (WrAddr),
    .wdata  (WrData),
    .raddr0 (pc_q),
    .raddr1 (pc1),
    .rdata0 (rd0),
    .rdata1 (rd1)
  );

  assign opcode   = rd0[OPC_HI:OPC_LO];
  assign is_mvi   = (opcode == OP_MVI);
  // An mvi consumes two words, so Last may be either of them.
  assign halt_hit = (last_q == pc_q) || (is_mvi && (last_q == pc1));

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    last_d   = last_q;
    perr_d   = perr_q;
    halted_d = 1'b0;
    ret_d    = ret_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_PEND;
          last_d  = Last;
          perr_d  = 1'b0;
          ret_d   = '0;
          pc_d    = '0;
        end
      end
      S_PEND: begin
        if (phase_q == 2'd3) state_d = S_RUN;
      end
      S_RUN: begin
        if ((phase_q == done_step(opcode)) != Done) perr_d = 1'b1;
        if (phase_q == 2'd3) begin
          ret_d = (&ret_q) ? ret_q : ret_q + 1'b1;
          pc_d  = is_mvi ? pc_q + 2'd2 : pc1;
          if (halt_hit) begin
            state_d  = S_IDLE;
            pc_d     = '0;
            halted_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Resetn) begin
      state_q  <= S_IDLE;
      phase_q  <= 2'd0;
      pc_q     <= '0;
      last_q   <= '0;
      perr_q   <= 1'b0;
      halted_q <= 1'b0;
      ret_q    <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_q + 2'd1;
      pc_q     <= pc_d;
      last_q   <= last_d;
      perr_q   <= perr_d;
      halted_q <= halted_d;
      ret_q    <= ret_d;
    end
  end

  assign Run      = (state_q == S_RUN);
  assign Busy     = (state_q != S_IDLE);
  assign DIN      = !Run ? '0 : ((phase_q != 2'd0 && is_mvi) ? rd1 : rd0);
  assign Halted   = halted_q;
  assign ProtoErr = perr_q;
  assign Retired  = ret_q;

endmodule

// File: tb/tb_instr_feeder.sv
// Directed bench for instr_feeder: frame-level vector table plus hand-written
// sequences for start alignment, busy-time writes/starts and mid-run reset.
module tb_instr_feeder;

  localparam int AW = 5;
  localparam int W  = 16;

  logic          Clock = 1'b0;
  logic          Resetn, WrEn, Start, Done;
  logic [AW-1:0] WrAddr, Last;
  logic [W-1:0]  WrData, DIN, Retired;
  logic          Run, Busy, Halted, ProtoErr;

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [1:0] ph;

  always #5 Clock = ~Clock;

  instr_feeder #(.AW(AW), .W(W)) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .WrEn     (WrEn),
    .WrAddr   (WrAddr),
    .WrData   (WrData),
    .Start    (Start),
    .Last     (Last),
    .DIN      (DIN),
    .Run      (Run),
    .Done     (Done),
    .Busy     (Busy),
    .Halted   (Halted),
    .ProtoErr (ProtoErr),
    .Retired  (Retired)
  );

  typedef struct {
    logic [15:0] din0;
    logic [15:0] din1;
    logic        long_op;
    logic        bad;
    logic        halt;
    logic        perr;
  } frame_t;

  frame_t ftab[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Advance one clock; ph mirrors the DUT step counter.
  task automatic tick();
    @(posedge Clock);
    if (Resetn) ph = 2'd0;
    else        ph = ph + 2'd1;
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [15:0] d);
    WrEn = 1'b1; WrAddr = a; WrData = d;
    tick();
    WrEn = 1'b0;
  endtask

  task automatic start_prog(input logic [AW-1:0] last, input logic we,
                            input logic [AW-1:0] a, input logic [15:0] d);
    Start = 1'b1; Last = last; WrEn = we; WrAddr = a; WrData = d;
    tick();
    Start = 1'b0; WrEn = 1'b0;
    chk("busy_after_start", Busy, 1);
    chk("perr_cleared", ProtoErr, 0);
    chk("retired_cleared", Retired, 0);
    for (int i = 0; i < 6 && !Run; i++) tick();
    chk("run_rise", Run, 1);
    chk("frame_align", ph, 0);
  endtask

  task automatic run_frame(input frame_t f);
    for (int i = 0; i < 4; i++) begin
      if (f.long_op) Done = f.bad ? (i == 1) : (i == 3);
      else           Done = f.bad ? (i == 3) : (i == 1);
      chk("run_in_frame", Run, 1);
      chk("din", DIN, (i == 0) ? f.din0 : f.din1);
      tick();
      WrEn = 1'b0; Start = 1'b0;
    end
    Done = 1'b0;
    chk("halted_at_end", Halted, f.halt);
    chk("busy_at_end", Busy, !f.halt);
    chk("perr_at_end", ProtoErr, f.perr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    Resetn = 1'b1; WrEn = 1'b0; Start = 1'b0; Done = 1'b0;
    WrAddr = '0; WrData = '0; Last = '0; ph = 2'd0;

    //                din0      din1      long bad halt perr
    ftab[0] = '{16'h0008, 16'h0008, 1'b0, 1'b0, 1'b1, 1'b0};
    ftab[1] = '{16'h0008, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b0};
    ftab[2] = '{16'h0041, 16'h5555, 1'b0, 1'b0, 1'b1, 1'b0};
    ftab[3] = '{16'h0050, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0};
    ftab[4] = '{16'h0092, 16'h0092, 1'b1, 1'b0, 1'b1, 1'b0};
    ftab[5] = '{16'h0092, 16'h0092, 1'b1, 1'b1, 1'b1, 1'b1};
    ftab[6] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    ftab[7] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};

    tick(); tick();
    Resetn = 1'b0;
    chk("rst_din", DIN, 0);
    chk("rst_run", Run, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_halted", Halted, 0);
    chk("rst_perr", ProtoErr, 0);
    chk("rst_retired", Retired, 0);

    // Single mv, Start issued at step 1
    wr(0, 16'h0008);
    while (ph != 2'd1) tick();
    start_prog(0, 1'b0, 0, 0);
    run_frame(ftab[0]);
    chk("mv_retired", Retired, 1);
    tick();
    chk("halt_pulse_one_cycle", Halted, 0);
    chk("run_low_after_halt", Run, 0);

    // mv x3 then mvi at 3 whose immediate word 4 is Last; word 4 written with Start
    wr(1, 16'h0008); wr(2, 16'h0008); wr(3, 16'h0041);
    start_prog(4, 1'b1, 4, 16'h5555);
    run_frame(ftab[1]); run_frame(ftab[1]); run_frame(ftab[1]);
    run_frame(ftab[2]);
    chk("mvi_last_retired", Retired, 4);

    // mvi R2 / add R2,R2
    wr(0, 16'h0050); wr(1, 16'h1234); wr(2, 16'h0092);
    start_prog(2, 1'b0, 0, 0);
    run_frame(ftab[3]); run_frame(ftab[4]);
    chk("add_retired", Retired, 2);

    // Done early on add: sticky error, run still completes
    start_prog(2, 1'b0, 0, 0);
    run_frame(ftab[3]); run_frame(ftab[5]);
    chk("bad_retired", Retired, 2);
    tick(); tick(); tick();
    chk("perr_held", ProtoErr, 1);

    // Write and Start while busy are both ignored
    start_prog(2, 1'b0, 0, 0);
    WrEn = 1'b1; WrAddr = 0; WrData = 16'hFFFF; Start = 1'b1;
    run_frame(ftab[3]); run_frame(ftab[4]);
    tick();
    chk("no_restart", Busy, 0);
    start_prog(2, 1'b0, 0, 0);
    run_frame(ftab[3]); run_frame(ftab[4]);

    // Reset at step 2 of frame 2
    start_prog(2, 1'b0, 0, 0);
    run_frame(ftab[3]);
    chk("f2_din", DIN, 16'h0092);
    tick(); tick();
    chk("at_step2", ph, 2);
    Resetn = 1'b1;
    tick();
    Resetn = 1'b0;
    chk("midrst_run", Run, 0);
    chk("midrst_busy", Busy, 0);
    chk("midrst_din", DIN, 0);
    chk("midrst_retired", Retired, 0);
    chk("midrst_halted", Halted, 0);
    start_prog(2, 1'b0, 0, 0);
    run_frame(ftab[3]); run_frame(ftab[4]);
    chk("rerun_retired", Retired, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_feeder.md
Name: instr_feeder

Overview:
Program-supply end of the processor's DIN/Run/Done instruction interface. It holds a small loadable program memory and drives DIN and Run, one instruction per 4-cycle step frame. For mvi it supplies the immediate word in step 1. It checks that the processor's Done arrives in the expected step, advances the program counter, and halts after a programmed last address. It sits beside the processor in the top level, replacing the manual switch-driven DIN/Run.

Parameters:
AW, 5, program address width; DEPTH = 2**AW words
W, 16, instruction/data word width

Ports:
Clock  in  1  system clock; all state updates on posedge
Resetn  in  1  synchronous, active-high reset (same net that clears the processor step counter)
WrEn  in  1  program-memory write strobe
WrAddr  in  AW  write address
WrData  in  W  write data
Start  in  1  begin execution at address 0
Last  in  AW  address of the last word of the program; latched when Start is accepted
DIN  out  W  word presented to the processor
Run  out  1  processor run enable
Done  in  1  processor instruction-complete flag
Busy  out  1  program executing or start pending
Halted  out  1  one-cycle pulse when the program finishes
ProtoErr  out  1  sticky flag: Done missing, or Done in the wrong step
Retired  out  W  instructions completed since the last accepted Start (saturating)

Behaviour:
- Reset (Resetn=1 at posedge) sets: state IDLE, phase=0, pc=0, DIN=0, Run=0, Busy=0, Halted=0, ProtoErr=0, Retired=0. Memory contents are not reset.
- Reset mid-run aborts immediately. The next cycle is IDLE with outputs at reset values.
- phase: 2-bit free-running counter, 0 after reset, incrementing every cycle. It mirrors the processor step count (step = phase).
- Memory: DEPTH x W register array with combinational read.
  - Write on posedge when WrEn=1 and Busy=0.
  - Writes while Busy=1 are dropped.
- States: IDLE, PEND, RUN.
  - IDLE: Run=0, DIN=0. Start=1 -> PEND; latch Last; clear ProtoErr and Retired; pc=0.
  - PEND: wait for frame alignment. When phase==3 -> RUN, so the first instruction begins at phase 0.
  - RUN: Run=1 for the whole frame.
    - phase 0: DIN=mem[pc].
    - phase 1: DIN=mem[pc+1] if opcode (bits 8:6 of mem[pc]) is 001 (mvi); else DIN=mem[pc].
    - phases 2-3: DIN holds the phase-1 value.
- Start while Busy is ignored.
- Done check, sampled each RUN cycle:
  - opcode 000/001: Done must be 1 at phase 1 and 0 at phases 0, 2, 3.
  - other opcodes: Done must be 1 at phase 3 only.
  - Any violation sets ProtoErr (sticky until the next accepted Start). Execution continues regardless.
- End of frame (phase 3, RUN):
  - Retired += 1, saturating at all-ones.
  - Advance pc by 2 (mvi) or 1. All pc arithmetic is modulo DEPTH, so pc+1 at DEPTH-1 wraps to 0.
  - Halt condition: Last is within the words consumed this frame (pc, or pc+1 for mvi). If so -> IDLE, pc=0, Halted=1 for one cycle, Run=0 from the next cycle.
- Busy = (state != IDLE).
- Simultaneous Start and WrEn in IDLE: the write is performed, then Start is accepted. The write lands before the first fetch.

Decomposition:
- Shared package (proc_pkg):
  - opcode constants OP_MV=3'b000, OP_MVI=3'b001, OP_ADD..OP_SRL=3'b010..3'b111
  - opcode field position 8:6
  - state encoding IDLE/PEND/RUN
  - DONE_STEP_SHORT=1, DONE_STEP_LONG=3
- One sub-module, prog_mem: register array with synchronous write port and combinational dual read (pc, pc+1).

Test Plan:
- Reset then idle -> DIN=0, Run=0, Busy=0, ProtoErr=0, Retired=0; writes at addr 3 = 16'h0041 take effect (read back via run).
- Load mem[0]=mv R1,R0 (9'o010), Last=0, Start at phase 1 -> Run rises at the next phase 0, DIN=0x0008 for 4 cycles. With Done pulsed at phase 1: Halted pulses at the frame end, Retired=1, ProtoErr=0.
- mem[0]=mvi R2 (9'o120), mem[1]=16'h1234, mem[2]=add R2,R2 (9'o222), Last=2 -> DIN=0x0050 at phase 0, then 0x1234 phases 1-3. Next frame DIN=0x0092 with Done at phase 3. Retired=2, Halted after frame 2.
- Same add program but Done given at phase 1 -> ProtoErr=1 and held. Execution completes; a new Start clears ProtoErr.
- WrEn to addr 0 with new data while Busy -> memory unchanged on the next run. Start pulse while Busy -> no restart.
- Resetn asserted at phase 2 of frame 2 -> next cycle Run=0, Busy=0, pc=0. Memory retained: a rerun produces identical DIN sequence.
